// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the PC, drives the combinational ROM address and registers the word toward decode.
// Latency: one cycle from imem_addr to out_instr. A stall holds the PC and outputs until id_ready; FETCH_HALT_DETECT_EN enables halt detection.
module instr_fetch_ctrl #(
    parameter int          MEM_SIZE = 1024,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        br_taken,
    input  logic [63:0] br_target,
    input  logic        id_ready,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [63:0] out_pc,
    output logic        fetch_err,
    output logic        halted
);

    localparam logic [1:0] FETCH = 2'd0;
    localparam logic [1:0] ERROR = 2'd1;
    localparam logic [1:0] HALT  = 2'd2;

    localparam logic [31:0] HALT_WORD = 32'h1400_0000;

    logic [1:0]  state;
    logic [63:0] pc;
    logic        legal;
    logic        advance;

    // 65-bit compare so a PC near the top of the address space cannot wrap into range.
    assign legal     = (pc[1:0] == 2'b00) && (({1'b0, pc} + 65'd3) < 65'(MEM_SIZE));
    assign advance   = (state == FETCH) && (!out_valid || id_ready);
    assign imem_addr = pc;

`ifdef FETCH_HALT_DETECT_EN
    logic halt_q;
    assign halted = halt_q;
`else
    assign halted = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            out_valid <= 1'b0;
            out_instr <= 32'h0;
            out_pc    <= 64'h0;
            fetch_err <= 1'b0;
`ifdef FETCH_HALT_DETECT_EN
            halt_q    <= 1'b0;
`endif
        end else begin
            case (state)
                FETCH: begin
                    if (br_taken) begin
                        pc        <= br_target;
                        out_valid <= 1'b0;
                    end else if (advance) begin
                        if (!legal) begin
                            state     <= ERROR;
                            fetch_err <= 1'b1;
                            out_valid <= 1'b0;
                        end else begin
                            out_instr <= imem_instr;
                            out_pc    <= pc;
                            out_valid <= 1'b1;
`ifdef FETCH_HALT_DETECT_EN
                            // The self-loop word is still delivered; the PC parks on it.
                            if (imem_instr == HALT_WORD) begin
                                state  <= HALT;
                                halt_q <= 1'b1;
                            end else begin
                                pc <= pc + 64'd4;
                            end
`else
                            pc <= pc + 64'd4;
`endif
                        end
                    end
                end
                HALT: begin
                    if (out_valid && id_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: vector table plus end-of-memory and halt sequences, checked through an expectation queue.
module tb_instr_fetch_ctrl;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        br;
        logic [63:0] tgt;
        logic        v;
        logic        dchk;
        logic [63:0] opc;
        logic [31:0] oi;
        logic [63:0] addr;
        logic        err;
        logic        hlt;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        br_taken;
    logic [63:0] br_target;
    logic        id_ready;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        fetch_err;
    logic        halted;

    logic [31:0] rom [0:255];
    vec_t        vecs [$];
    vec_t        expq [$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    assign imem_instr = (imem_addr < 64'd1024) ? rom[imem_addr[9:2]] : 32'hDEAD_BEEF;

    instr_fetch_ctrl #(.MEM_SIZE(1024), .RESET_PC(64'h0)) dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_instr(imem_instr),
        .br_taken(br_taken), .br_target(br_target), .id_ready(id_ready),
        .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
        .fetch_err(fetch_err), .halted(halted)
    );

    function automatic logic [31:0] w(int i);
        return 32'h1000_0000 + i;
    endfunction

    function automatic vec_t mk(logic rst, logic rdy, logic br, logic [63:0] tgt,
                                logic v, logic dchk, logic [63:0] opc, logic [31:0] oi,
                                logic [63:0] addr, logic err, logic hlt);
        vec_t r;
        r.rst = rst; r.rdy = rdy; r.br = br; r.tgt = tgt;
        r.v = v; r.dchk = dchk; r.opc = opc; r.oi = oi;
        r.addr = addr; r.err = err; r.hlt = hlt;
        return r;
    endfunction

    task automatic chk(string name, int idx, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare after the edge.
    task automatic step(vec_t s, int idx);
        vec_t e;
        @(negedge clk);
        reset     = s.rst;
        id_ready  = s.rdy;
        br_taken  = s.br;
        br_target = s.tgt;
        expq.push_back(s);
        @(posedge clk);
        #1;
        e = expq.pop_front();
        chk("out_valid", idx, 64'(out_valid), 64'(e.v));
        chk("imem_addr", idx, imem_addr, e.addr);
        chk("fetch_err", idx, 64'(fetch_err), 64'(e.err));
        chk("halted", idx, 64'(halted), 64'(e.hlt));
        if (e.dchk) begin
            chk("out_pc", idx, out_pc, e.opc);
            chk("out_instr", idx, 64'(out_instr), 64'(e.oi));
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = w(i);
        reset = 1'b1; id_ready = 1'b0; br_taken = 1'b0; br_target = 64'h0;

        // Reset, streaming, stall, redirect, misaligned redirect, reset mid-stall.
        vecs.push_back(mk(1,0,0,64'h0,   0,1,64'h0, 32'h0, 64'h0,   0,0));
        vecs.push_back(mk(0,1,0,64'h0,   1,1,64'h0, w(0),  64'h4,   0,0));
        vecs.push_back(mk(0,1,0,64'h0,   1,1,64'h4, w(1),  64'h8,   0,0));
        vecs.push_back(mk(0,1,0,64'h0,   1,1,64'h8, w(2),  64'hC,   0,0));
        vecs.push_back(mk(0,1,0,64'h0,   1,1,64'hC, w(3),  64'h10,  0,0));
        vecs.push_back(mk(1,1,1,64'h40,  0,1,64'h0, 32'h0, 64'h0,   0,0));
        vecs.push_back(mk(0,0,0,64'h0,   1,1,64'h0, w(0),  64'h4,   0,0));
        vecs.push_back(mk(0,0,0,64'h0,   1,1,64'h0, w(0),  64'h4,   0,0));
        vecs.push_back(mk(0,0,0,64'h0,   1,1,64'h0, w(0),  64'h4,   0,0));
        vecs.push_back(mk(0,0,0,64'h0,   1,1,64'h0, w(0),  64'h4,   0,0));
        vecs.push_back(mk(0,1,0,64'h0,   1,1,64'h4, w(1),  64'h8,   0,0));
        vecs.push_back(mk(0,0,0,64'h0,   1,1,64'h4, w(1),  64'h8,   0,0));
        vecs.push_back(mk(0,0,1,64'h40,  0,0,64'h0, 32'h0, 64'h40,  0,0));
        vecs.push_back(mk(0,0,0,64'h0,   1,1,64'h40,w(16), 64'h44,  0,0));
        vecs.push_back(mk(0,1,1,64'h3FE, 0,0,64'h0, 32'h0, 64'h3FE, 0,0));
        vecs.push_back(mk(0,1,0,64'h0,   0,0,64'h0, 32'h0, 64'h3FE, 1,0));
        vecs.push_back(mk(0,1,1,64'h80,  0,0,64'h0, 32'h0, 64'h3FE, 1,0));
        vecs.push_back(mk(0,0,0,64'h0,   0,0,64'h0, 32'h0, 64'h3FE, 1,0));
        vecs.push_back(mk(1,0,0,64'h0,   0,1,64'h0, 32'h0, 64'h0,   0,0));
        vecs.push_back(mk(0,0,0,64'h0,   1,1,64'h0, w(0),  64'h4,   0,0));
        vecs.push_back(mk(0,0,0,64'h0,   1,1,64'h0, w(0),  64'h4,   0,0));
        vecs.push_back(mk(1,0,0,64'h0,   0,1,64'h0, 32'h0, 64'h0,   0,0));
        vecs.push_back(mk(0,1,0,64'h0,   1,1,64'h0, w(0),  64'h4,   0,0));
        for (int i = 0; i < vecs.size(); i++) step(vecs[i], i);

        // Sequential run to the end of the ROM, error at 0x400, recovery by reset.
        step(mk(1,0,0,64'h0, 0,1,64'h0,32'h0,64'h0, 0,0), 100);
        for (int i = 0; i < 256; i++)
            step(mk(0,1,0,64'h0, 1,1,64'(4*i), w(i), 64'(4*i+4), 0,0), 200 + i);
        step(mk(0,1,0,64'h0, 0,0,64'h0,32'h0,64'h400, 1,0), 500);
        step(mk(0,1,1,64'h0, 0,0,64'h0,32'h0,64'h400, 1,0), 501);
        step(mk(1,1,0,64'h0, 0,1,64'h0,32'h0,64'h0,   0,0), 502);
        step(mk(0,1,0,64'h0, 1,1,64'h0,w(0), 64'h4,   0,0), 503);

        // Self-loop word at address 8.
        rom[2] = 32'h1400_0000;
        step(mk(1,0,0,64'h0, 0,1,64'h0,32'h0,64'h0, 0,0), 600);
        step(mk(0,1,0,64'h0, 1,1,64'h0,w(0),64'h4, 0,0), 601);
        step(mk(0,1,0,64'h0, 1,1,64'h4,w(1),64'h8, 0,0), 602);
`ifdef FETCH_HALT_DETECT_EN
        step(mk(0,1,0,64'h0, 1,1,64'h8,32'h1400_0000,64'h8, 0,1), 603);
        step(mk(0,0,0,64'h0, 1,1,64'h8,32'h1400_0000,64'h8, 0,1), 604);
        step(mk(0,1,0,64'h0, 0,0,64'h0,32'h0,64'h8, 0,1), 605);
        step(mk(0,1,1,64'h0, 0,0,64'h0,32'h0,64'h8, 0,1), 606);
`else
        step(mk(0,1,0,64'h0, 1,1,64'h8,32'h1400_0000,64'hC, 0,0), 603);
        step(mk(0,0,0,64'h0, 1,1,64'h8,32'h1400_0000,64'hC, 0,0), 604);
        step(mk(0,1,0,64'h0, 1,1,64'hC,w(3),64'h10, 0,0), 605);
        step(mk(0,1,1,64'h0, 0,0,64'h0,32'h0,64'h0, 0,0), 606);
`endif
        rom[2] = w(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_ctrl.md
Name: instr_fetch_ctrl

Overview:
Fetch sequencer for the 64-bit single-issue core. Owns the program counter and drives the byte address of the combinational 32-bit instruction ROM. Captures the returned word into an IF/ID output register with a valid/ready handshake toward decode. Handles branch redirects, back-pressure stalls and out-of-range or misaligned fetch errors.

Parameters:
MEM_SIZE, 1024, instruction ROM size in bytes; power of two, > 4
RESET_PC, 64'h0, PC value loaded on reset; must be word-aligned

Ports:
clk  input  1  system clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
imem_addr  output  64  byte address to instruction ROM; always equals pc
imem_instr  input  32  instruction word returned combinationally for imem_addr
br_taken  input  1  redirect request from execute; sampled at posedge
br_target  input  64  redirect byte address
id_ready  input  1  decode accepts out_instr this cycle
out_valid  output  1  out_instr/out_pc hold a valid fetched instruction
out_instr  output  32  registered instruction
out_pc  output  64  byte address of out_instr
fetch_err  output  1  sticky error flag; fetch stopped
halted  output  1  fetch stopped by halt detection (see Optional Feature)

Behaviour:
- States: FETCH, ERROR, HALT. Reset -> FETCH. pc=RESET_PC, out_valid=0, out_instr=0, out_pc=0, fetch_err=0, halted=0.
- imem_addr = pc (combinational from register). ROM latency is 0. The word is captured at the same posedge that advances pc.
- Fetch legality: pc[1:0]==0 and pc+3 < MEM_SIZE. Evaluate the compare in 64 bits with no wrap; pc near 2^64 is illegal.
- advance = (state==FETCH) && (!out_valid || id_ready).
- Priority per posedge, highest first:
  1. reset.
  2. br_taken in FETCH: pc<=br_target and out_valid<=0 (flush). No capture this cycle, even if advance.
  3. advance with illegal pc: state<=ERROR, fetch_err<=1, out_valid<=0.
  4. advance with legal pc: out_instr<=imem_instr, out_pc<=pc, out_valid<=1, pc<=pc+4.
  5. Stall (out_valid && !id_ready): hold pc and all outputs.
- The handshake completes when out_valid && id_ready. A new word may be captured in the same cycle, giving one instruction per cycle sustained.
- An illegal br_target is accepted into pc. The error is raised on the next advance, so a flush-then-error takes 2 cycles.
- ERROR: pc frozen. out_valid=0. br_taken and id_ready are ignored. Only reset exits. fetch_err stays 1.
- HALT: as ERROR but halted=1 and fetch_err=0. br_taken is ignored.
- Sequential PC increment wraps modulo 2^64. Wrap is unreachable while legal, because the bound check fires first.
- Reset mid-stall or mid-redirect fully discards the pending word and the target.
- out_instr/out_pc are don't-care when out_valid=0. They are not cleared on flush.

Optional Feature:
Macro FETCH_HALT_DETECT_EN.
- Defined: on a legal capture where imem_instr==32'h14000000 (unconditional B with offset 0, the self-loop that ends test programs), the word is still presented with out_valid=1. state<=HALT and halted<=1 at that same edge. No further fetch. That last word stays valid until id_ready, then out_valid<=0.
- Not defined: halted is tied to 0, HALT is unreachable, and the self-loop word is fetched repeatedly like any other branch.

Test Plan:
- Reset with RESET_PC=0, ROM words 0..3 distinct, id_ready=1 -> out_pc 0,4,8,12 on consecutive cycles, each out_valid=1 with the matching word; imem_addr leads out_pc by 4.
- Hold id_ready=0 for 3 cycles after the first capture -> out_pc stays 0, out_instr stable, imem_addr stays 4; release -> next out_pc=4.
- br_taken=1, br_target=0x40 while stalled -> next cycle out_valid=0 and imem_addr=0x40; following cycle out_pc=0x40.
- br_target=0x3FE (misaligned) -> one flush cycle, then fetch_err=1, out_valid=0, imem_addr frozen at 0x3FE; later br_taken is ignored.
- Sequential run to pc=0x3FC with MEM_SIZE=1024 -> 0x3FC is captured; next advance at pc=0x400 raises fetch_err=1. Reset then restores pc=0, fetch_err=0.
- With FETCH_HALT_DETECT_EN, ROM[2]=32'h14000000 -> words at 0,4,8 delivered, halted=1 at the capture of 8, imem_addr stays 8, no fetch from 12; without the macro, the pc keeps advancing to 12.
